// File: rtl/pc_recovery_ctrl.sv
// Next-PC generator for the Hamming-protected PC register. On an uncorrectable
// PC error it replays from the last confirmed successor, retries, then traps.
module pc_recovery_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [31:0]          pc_corrected,
    input  logic                 pc_double_err,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    output logic [31:0]          next_pc,
    output logic                 commit_en,
    output logic                 recovery_active,
    output logic                 fault,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned    RW         = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [RW-1:0]  RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef enum logic [1:0] {
        S_NORMAL,
        S_REPLAY,
        S_CHECK,
        S_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic                   pc_vld_d1_q;
    logic [31:0]            next_d1_q;
    logic [31:0]            resume_pc_q, resume_pc_d;
    logic [RW-1:0]          retry_cnt_q, retry_cnt_d;
    logic                   fault_q, fault_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    logic [31:0]            seq_pc;
    logic                   flag;

    assign seq_pc = branch_taken ? branch_target : pc_corrected + 32'd4;
    // The flag refers to the previous cycle's PC, which does not exist right after reset.
    assign flag   = pc_double_err & pc_vld_d1_q;

    always_comb begin
        state_d     = state_q;
        resume_pc_d = resume_pc_q;
        retry_cnt_d = retry_cnt_q;
        fault_d     = fault_q;
        err_count_d = err_count_q;
        next_pc     = seq_pc;
        commit_en   = 1'b0;
        unique case (state_q)
            S_NORMAL: begin
                if (flag) begin
                    next_pc     = resume_pc_q;
                    retry_cnt_d = '0;
                    state_d     = S_REPLAY;
                    if (err_count_q != {ERR_CNT_W{1'b1}})
                        err_count_d = err_count_q + ERR_CNT_W'(1);
                end else if (pc_vld_d1_q) begin
                    commit_en   = 1'b1;
                    resume_pc_d = next_d1_q;
                end
            end
            // The flag this cycle belongs to the discarded value; only the replay's successor matters.
            S_REPLAY: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!flag) begin
                    commit_en   = 1'b1;
                    resume_pc_d = next_d1_q;
                    state_d     = S_NORMAL;
                end else if (retry_cnt_q != RETRY_LAST) begin
                    retry_cnt_d = retry_cnt_q + RW'(1);
                    next_pc     = resume_pc_q;
                    state_d     = S_REPLAY;
                end else begin
                    next_pc = TRAP_VECTOR;
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                next_pc = TRAP_VECTOR;
            end
            default: begin
                state_d = S_NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= S_NORMAL;
            pc_vld_d1_q <= 1'b0;
            next_d1_q   <= RESET_VECTOR;
            resume_pc_q <= RESET_VECTOR;
            retry_cnt_q <= '0;
            fault_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_vld_d1_q <= 1'b1;
            next_d1_q   <= seq_pc;
            resume_pc_q <= resume_pc_d;
            retry_cnt_q <= retry_cnt_d;
            fault_q     <= fault_d;
            err_count_q <= err_count_d;
        end
    end

    assign recovery_active = (state_q != S_NORMAL);
    assign fault           = fault_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_pc_recovery_ctrl.sv
// Bench for pc_recovery_ctrl: directed scenarios plus random traffic, all scored
// against an event-level recovery model (attempt counting, confirmed resume point).
module tb_pc_recovery_ctrl;

    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;
    localparam int          MAXR  = 3;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] pc_corrected;
    logic        pc_double_err;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic [31:0] next_pc, next_pc2;
    logic        commit_en, commit_en2;
    logic        recovery_active, recovery_active2;
    logic        fault, fault2;
    logic [7:0]  err_count;
    logic [1:0]  err_count2;

    pc_recovery_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .MAX_RETRY(MAXR), .ERR_CNT_W(8)) dut (
        .clk(clk), .rstN(rstN), .pc_corrected(pc_corrected), .pc_double_err(pc_double_err),
        .branch_taken(branch_taken), .branch_target(branch_target), .next_pc(next_pc),
        .commit_en(commit_en), .recovery_active(recovery_active), .fault(fault), .err_count(err_count));

    pc_recovery_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .MAX_RETRY(MAXR), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rstN(rstN), .pc_corrected(pc_corrected), .pc_double_err(pc_double_err),
        .branch_taken(branch_taken), .branch_target(branch_target), .next_pc(next_pc2),
        .commit_en(commit_en2), .recovery_active(recovery_active2), .fault(fault2), .err_count(err_count2));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a recovery "event" is in progress (m_busy), m_tries replays have been
    // issued, and m_verdict marks the cycle that judges the latest replay.
    bit          m_vld, m_busy, m_verdict, m_fault;
    int          m_tries, m_err;
    logic [31:0] m_prev_seq, m_resume;
    logic [31:0] exp_np;
    bit          exp_ce, exp_ra;
    logic [31:0] last_np;
    logic [31:0] obs_np;
    bit          obs_ce, obs_ra, obs_fault;
    logic [7:0]  obs_err;
    logic [1:0]  obs_err2;

    task automatic model_reset();
        m_vld = 0; m_busy = 0; m_verdict = 0; m_fault = 0;
        m_tries = 0; m_err = 0; m_prev_seq = RV; m_resume = RV;
    endtask

    task automatic model_eval(input bit adv);
        logic [31:0] seq;
        bit flag;
        bit confirm;
        seq     = branch_taken ? branch_target : pc_corrected + 32'd4;
        flag    = pc_double_err && m_vld;
        exp_ra  = m_fault || m_busy;
        exp_np  = seq;
        exp_ce  = 0;
        confirm = 0;
        if (m_fault) begin
            exp_np = TV;
        end else if (!m_busy) begin
            if (flag) begin
                exp_np = m_resume;
                if (adv) begin m_busy = 1; m_verdict = 0; m_tries = 1; m_err++; end
            end else if (m_vld) begin
                exp_ce = 1; confirm = 1;
            end
        end else if (!m_verdict) begin
            if (adv) m_verdict = 1;
        end else if (!flag) begin
            exp_ce = 1; confirm = 1;
            if (adv) m_busy = 0;
        end else if (m_tries < MAXR) begin
            exp_np = m_resume;
            if (adv) begin m_tries++; m_verdict = 0; end
        end else begin
            exp_np = TV;
            if (adv) begin m_fault = 1; m_busy = 0; end
        end
        if (adv) begin
            if (confirm) m_resume = m_prev_seq;
            m_prev_seq = seq;
            m_vld = 1;
        end
    endtask

    task automatic check_outs(input string tag);
        obs_np = next_pc; obs_ce = commit_en; obs_ra = recovery_active;
        obs_fault = fault; obs_err = err_count; obs_err2 = err_count2;
        chk({tag, ".next_pc"}, next_pc, exp_np);
        chk({tag, ".commit_en"}, {31'd0, commit_en}, {31'd0, exp_ce});
        chk({tag, ".recovery_active"}, {31'd0, recovery_active}, {31'd0, exp_ra});
        chk({tag, ".fault"}, {31'd0, fault}, {31'd0, m_fault});
        chk({tag, ".err_count"}, {24'd0, err_count}, (m_err > 255) ? 32'd255 : m_err);
        chk({tag, ".err_count_w2"}, {30'd0, err_count2}, (m_err > 3) ? 32'd3 : m_err);
        chk({tag, ".next_pc_w2"}, next_pc2, exp_np);
    endtask

    // Called at posedge+1; outputs are sampled at the following negedge.
    task automatic step(input logic [31:0] pc, input logic err, input logic br, input logic [31:0] tgt);
        pc_corrected = pc; pc_double_err = err; branch_taken = br; branch_target = tgt;
        @(negedge clk);
        model_eval(0);
        check_outs("step");
        model_eval(1);
        last_np = exp_np;
        @(posedge clk);
        #1;
    endtask

    // Reset is dropped between edges and outputs are checked before any edge arrives.
    task automatic apply_reset();
        rstN = 1'b0;
        #1;
        model_reset();
        model_eval(0);
        check_outs("reset");
        @(posedge clk);
        #1;
        rstN = 1'b1;
        last_np = RV;
    endtask

    task automatic run_to(input logic [31:0] pc_end);
        while (last_np != pc_end) step(last_np, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b1;
        pc_corrected = 32'd0; pc_double_err = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        #1;
        apply_reset();

        // sequential fetch from the reset vector
        for (int i = 0; i < 5; i++) begin
            step(last_np, 1'b0, 1'b0, 32'd0);
            chk("seq.np", obs_np, 32'd4 * (i + 1));
            chk("seq.ce", {31'd0, obs_ce}, (i > 0) ? 32'd1 : 32'd0);
        end
        chk("seq.err", {24'd0, obs_err}, 32'd0);

        // taken branch, then resume point proven by a subsequent error
        apply_reset();
        step(32'h3C, 1'b0, 1'b0, 32'd0);
        step(32'h40, 1'b0, 1'b1, 32'h200);
        chk("br.np", obs_np, 32'h200);
        step(32'h200, 1'b0, 1'b0, 32'd0);
        chk("br.ce", {31'd0, obs_ce}, 32'd1);
        step(32'h204, 1'b1, 1'b0, 32'd0);
        chk("br.resume", obs_np, 32'h200);
        step(32'h200, 1'b0, 1'b0, 32'd0);
        step(32'h204, 1'b0, 1'b0, 32'd0);

        // single error recovered on first check
        apply_reset();
        run_to(32'h18);
        step(32'h18, 1'b1, 1'b0, 32'd0);
        chk("err.np", obs_np, 32'h14);
        chk("err.ce", {31'd0, obs_ce}, 32'd0);
        step(32'h14, 1'b1, 1'b0, 32'd0);
        chk("err.replay_np", obs_np, 32'h18);
        chk("err.replay_ra", {31'd0, obs_ra}, 32'd1);
        chk("err.cnt", {24'd0, obs_err}, 32'd1);
        step(32'h18, 1'b0, 1'b0, 32'd0);
        chk("err.check_ce", {31'd0, obs_ce}, 32'd1);
        step(32'h1C, 1'b0, 1'b0, 32'd0);
        chk("err.back_normal", {31'd0, obs_ra}, 32'd0);

        // retries exhausted -> trap and lock
        apply_reset();
        run_to(32'h18);
        step(32'h18, 1'b1, 1'b0, 32'd0);
        for (int r = 0; r < MAXR; r++) begin
            step(32'h14, 1'b0, 1'b0, 32'd0);
            step(32'h18, 1'b1, 1'b0, 32'd0);
        end
        chk("trap.np", obs_np, TV);
        for (int i = 0; i < 10; i++) begin
            step($urandom, 1'($urandom), 1'($urandom), $urandom);
            chk("fault.np", obs_np, TV);
            chk("fault.flag", {31'd0, obs_fault}, 32'd1);
        end
        chk("fault.ra", {31'd0, obs_ra}, 32'd1);
        chk("fault.err", {24'd0, obs_err}, 32'd1);

        // narrow counter saturation over five separate events
        apply_reset();
        run_to(32'h10);
        for (int e = 1; e <= 5; e++) begin
            step(last_np, 1'b1, 1'b0, 32'd0);
            step(last_np, 1'b0, 1'b0, 32'd0);
            chk("sat.cnt", {30'd0, obs_err2}, (e > 3) ? 32'd3 : e);
            step(last_np, 1'b0, 1'b0, 32'd0);
            step(last_np, 1'b0, 1'b0, 32'd0);
        end

        // asynchronous reset while in CHECK
        run_to(32'h100);
        step(32'h100, 1'b1, 1'b0, 32'd0);
        step(32'hFC, 1'b0, 1'b0, 32'd0);
        pc_corrected = 32'h100; pc_double_err = 1'b1;
        #2;
        apply_reset();
        chk("arst.np", obs_np, 32'h104);
        chk("arst.ra", {31'd0, obs_ra}, 32'd0);
        chk("arst.err", {24'd0, obs_err}, 32'd0);
        step(32'h0, 1'b1, 1'b0, 32'd0);
        chk("arst.first_flag_ignored", obs_np, 32'h4);
        step(32'h4, 1'b1, 1'b0, 32'd0);
        chk("arst.resume_vec", obs_np, RV);
        step(32'h0, 1'b0, 1'b0, 32'd0);
        step(32'h4, 1'b0, 1'b0, 32'd0);

        // address wrap
        step(32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
        chk("wrap.np", obs_np, 32'h0);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] pc;
            if ($urandom_range(0, 199) == 0) apply_reset();
            pc = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFC) : last_np;
            step(pc, $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFFC);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pc_recovery_ctrl.md
Name: pc_recovery_ctrl

Overview:
- Next-PC generator and double-error recovery controller for the single-cycle RISC-V core.
- Sits directly upstream of the Hamming-protected PC register. Consumes its corrected PC and its registered double-error flag, and produces the next PC that the register stores.
- On an uncorrectable PC error it suppresses commit, replays from the last confirmed successor PC, and retries up to a bound. After that it vectors to a trap address and locks in FAULT.

Parameters:
RESET_VECTOR, 32'h0000_0000, must equal the PC register reset value; initial resume_pc.
TRAP_VECTOR, 32'h0000_0100, PC driven once retries are exhausted.
MAX_RETRY, 3, replay attempts per error event (>=1).
ERR_CNT_W, 8, width of the saturating error-event counter.

Ports:
clk  in  1  core clock
rstN  in  1  reset; asynchronous, active-low
pc_corrected  in  32  corrected PC from protected PC register (value fetched this cycle)
pc_double_err  in  1  uncorrectable error on the PC value presented in the PREVIOUS cycle
branch_taken  in  1  current instruction redirects
branch_target  in  32  redirect target
next_pc  out  32  value loaded into PC register at next edge (combinational)
commit_en  out  1  instruction fetched in the previous cycle may write back (combinational)
recovery_active  out  1  state != NORMAL
fault  out  1  sticky; set on entry to FAULT
err_count  out  ERR_CNT_W  saturating count of double-error events

Behaviour:
- seq_pc = branch_taken ? branch_target : pc_corrected + 32'd4 (mod 2^32; target used unmodified).
- Registers:
  - pc_vld_d1: 0 in the first cycle after reset, else 1.
  - next_d1 <= seq_pc every cycle.
  - resume_pc.
  - state.
  - retry_cnt.
  - fault.
  - err_count.
- Reset (asynchronous, immediate, also mid-recovery): state=NORMAL, resume_pc=RESET_VECTOR, next_d1=RESET_VECTOR, pc_vld_d1=0, retry_cnt=0, fault=0, err_count=0.
- Post-reset outputs: next_pc = seq_pc, commit_en=0, recovery_active=0.
- "Confirm" means commit_en=1 and resume_pc <= next_d1.
- States NORMAL, REPLAY, CHECK, FAULT:
  - NORMAL, flag=0: next_pc=seq_pc; confirm if pc_vld_d1.
  - NORMAL, flag=1: next_pc=resume_pc, commit_en=0, err_count++ (saturate at all-ones), retry_cnt<=0, go to REPLAY.
  - REPLAY (pc_corrected = replayed resume_pc; flag refers to the discarded value and is ignored): next_pc=seq_pc, commit_en=0, go to CHECK.
  - CHECK, flag=0: next_pc=seq_pc, confirm, go to NORMAL.
  - CHECK, flag=1 and retry_cnt < MAX_RETRY-1: retry_cnt++, next_pc=resume_pc, commit_en=0, go to REPLAY. err_count is NOT incremented (same event).
  - CHECK, flag=1 and retry_cnt == MAX_RETRY-1: next_pc=TRAP_VECTOR, commit_en=0, fault<=1, go to FAULT.
  - FAULT: next_pc=TRAP_VECTOR, commit_en=0; leaves only via rstN.
- Latency:
  - Error flagged at cycle t.
  - Replayed PC appears at t+1.
  - Verdict on the replay at t+2.
  - Minimum recovery penalty is 2 cycles.
- branch_* inputs are honoured in REPLAY/CHECK (they describe the replayed instruction). They are ignored whenever next_pc is forced.
- pc_double_err in the first cycle after reset is treated as 0.

Test Plan:
- Reset release, branch_taken=0, no errors, 5 cycles -> next_pc 0x4, 0x8, 0xC, 0x10, 0x14; commit_en 0 then 1; err_count=0.
- At pc=0x40, branch_taken=1, target=0x200 -> next_pc=0x200; the following cycle commit_en=1 and resume_pc=0x200.
- pc sequence 0x10, 0x14; flag=1 in the cycle pc=0x18 (error on 0x14; resume_pc=0x14 after confirming 0x10) -> next_pc=0x14, commit_en=0, err_count=1.
  - Next cycle: state REPLAY, next_pc=0x18.
  - Following cycle: flag=0, commit_en=1, state NORMAL.
- Same stimulus but flag=1 in every CHECK, MAX_RETRY=3 -> three replays of 0x14, then next_pc=0x100, fault=1, recovery_active=1.
  - err_count stays 1.
  - Held in FAULT for 10 cycles regardless of inputs.
- ERR_CNT_W=2, five separated error events, each recovering on the first CHECK -> err_count 1, 2, 3, 3, 3.
- Assert rstN low while in CHECK -> all outputs/registers return to reset values immediately, without waiting for a clock edge; the next error after release is handled from NORMAL.
- pc_corrected=0xFFFF_FFFC, no branch -> next_pc=0x0000_0000 (wrap).
